// File: rtl/rx_dcm_pkg.sv
// Shared types and width helpers for the rx DCM reset/lock sequencer.
package rx_dcm_pkg;

   typedef enum logic [2:0] {
      RESET_DCM = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } rx_dcm_state_e;

   // Bits needed for a counter that runs 0..n-1.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // One counter is shared by every timed state, so it must fit the longest span.
   function automatic int seq_cnt_w(input int pulse, input int timeout, input int stable);
      int w;
      w = cnt_w(pulse);
      if (cnt_w(timeout) > w) w = cnt_w(timeout);
      if (cnt_w(stable) > w) w = cnt_w(stable);
      return w;
   endfunction

   function automatic int retry_w(input int max_retries);
      return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
   endfunction

endpackage

// File: rtl/rx_sync2.sv
// Generic two-flop synchronizer with asynchronous active-high reset to 0.
module rx_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/rx_dcm_ctrl.sv
// DCM reset/lock sequencer clocked by the free-running pre-DCM clock.
// Define RX_DCM_LOSS_CNT_EN to add loss_cnt, a saturating count of lock losses seen in RUN.
module rx_dcm_ctrl
   import rx_dcm_pkg::*;
#(
   parameter int RST_PULSE_CYCLES   = 8,
   parameter int LOCK_TIMEOUT       = 65536,
   parameter int LOCK_STABLE_CYCLES = 64,
   parameter int MAX_RETRIES        = 4
) (
   input  logic                            rxclk_in,
   input  logic                            reset,
   input  logic                            dcm_locked,
   input  logic                            relock_req,
   output logic                            dcm_rst,
   output logic                            rx_reset,
   output logic                            dcm_ready,
   output logic                            lock_fail,
   output logic [retry_w(MAX_RETRIES)-1:0] retry_cnt
`ifdef RX_DCM_LOSS_CNT_EN
   ,
   output logic [7:0]                      loss_cnt
`endif
);

   localparam int CNT_W   = seq_cnt_w(RST_PULSE_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
   localparam int RETRY_W = retry_w(MAX_RETRIES);

   localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   rx_dcm_state_e      r_state;
   rx_dcm_state_e      w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [RETRY_W-1:0] r_retry;
   logic [RETRY_W-1:0] w_retry_nxt;
   logic               r_dcm_rst;
   logic               r_rx_reset;
   logic               r_dcm_ready;
   logic               r_lock_fail;
   logic               w_locked_s;

   rx_sync2 #(
      .WIDTH (1)
   ) u_lock_sync (
      .i_clk (rxclk_in),
      .i_rst (reset),
      .i_d   (dcm_locked),
      .o_q   (w_locked_s)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_nxt = r_retry;

      case (r_state)
         RESET_DCM: begin
            if (r_cnt == PULSE_LAST) begin
               w_state_nxt = WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         // Lock is checked before the timeout so a coincident lock wins.
         WAIT_LOCK: begin
            if (w_locked_s) begin
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_cnt_nxt = '0;
               if (r_retry == RETRY_MAX) begin
                  w_state_nxt = FAIL;
               end else begin
                  w_state_nxt = RESET_DCM;
                  w_retry_nxt = r_retry + RETRY_W'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         STABLE: begin
            if (!w_locked_s) begin
               w_state_nxt = WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == STABLE_LAST) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (!w_locked_s) begin
               w_state_nxt = RESET_DCM;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end
         end
         FAIL: begin
            w_state_nxt = FAIL;
         end
         default: begin
            w_state_nxt = RESET_DCM;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
         end
      endcase

      // A relock request restarts the sequence from anywhere except an ongoing DCM reset pulse.
      if (relock_req && (r_state != RESET_DCM)) begin
         w_state_nxt = RESET_DCM;
         w_cnt_nxt   = '0;
         w_retry_nxt = '0;
      end
   end

   always_ff @(posedge rxclk_in or posedge reset) begin
      if (reset) begin
         r_state <= RESET_DCM;
         r_cnt   <= '0;
         r_retry <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_retry <= w_retry_nxt;
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge rxclk_in or posedge reset) begin
      if (reset) begin
         r_dcm_rst   <= 1'b1;
         r_rx_reset  <= 1'b1;
         r_dcm_ready <= 1'b0;
         r_lock_fail <= 1'b0;
      end else begin
         r_dcm_rst   <= (w_state_nxt == RESET_DCM);
         r_rx_reset  <= (w_state_nxt != RUN);
         r_dcm_ready <= (w_state_nxt == RUN);
         r_lock_fail <= (w_state_nxt == FAIL);
      end
   end

   assign dcm_rst   = r_dcm_rst;
   assign rx_reset  = r_rx_reset;
   assign dcm_ready = r_dcm_ready;
   assign lock_fail = r_lock_fail;
   assign retry_cnt = r_retry;

`ifdef RX_DCM_LOSS_CNT_EN
   logic [7:0] r_loss_cnt;
   logic       w_loss_evt;

   // In RUN a low synced lock always forces RESET_DCM, with or without a relock request.
   assign w_loss_evt = (r_state == RUN) && !w_locked_s;

   always_ff @(posedge rxclk_in or posedge reset) begin
      if (reset) begin
         r_loss_cnt <= 8'd0;
      end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
         r_loss_cnt <= r_loss_cnt + 8'd1;
      end
   end

   assign loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_rx_dcm_ctrl.sv
// Scoreboard bench for rx_dcm_ctrl: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_rx_dcm_ctrl;

   localparam int RP = 4;
   localparam int LT = 32;
   localparam int LS = 8;
   localparam int MR = 2;

   logic       rxclk_in   = 1'b0;
   logic       reset      = 1'b1;
   logic       dcm_locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       dcm_rst;
   logic       rx_reset;
   logic       dcm_ready;
   logic       lock_fail;
   logic [1:0] retry_cnt;
`ifdef RX_DCM_LOSS_CNT_EN
   logic [7:0] loss_cnt;
`endif

   always #5 rxclk_in = ~rxclk_in;

   rx_dcm_ctrl #(
      .RST_PULSE_CYCLES   (RP),
      .LOCK_TIMEOUT       (LT),
      .LOCK_STABLE_CYCLES (LS),
      .MAX_RETRIES        (MR)
   ) dut (
      .rxclk_in   (rxclk_in),
      .reset      (reset),
      .dcm_locked (dcm_locked),
      .relock_req (relock_req),
      .dcm_rst    (dcm_rst),
      .rx_reset   (rx_reset),
      .dcm_ready  (dcm_ready),
      .lock_fail  (lock_fail),
      .retry_cnt  (retry_cnt)
`ifdef RX_DCM_LOSS_CNT_EN
      ,
      .loss_cnt   (loss_cnt)
`endif
   );

   typedef struct {
      int         cyc;
      logic [5:0] exp;
      logic [7:0] exp_loss;
      string      name;
   } chk_t;

   chk_t sbq[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always @(posedge rxclk_in) cyc <= cyc + 1;

   // Expected output words {dcm_rst, rx_reset, dcm_ready, lock_fail, retry_cnt}
   function automatic logic [5:0] o_rst(input logic [1:0] rc);
      return {4'b1100, rc};
   endfunction
   function automatic logic [5:0] o_wait(input logic [1:0] rc);
      return {4'b0100, rc};
   endfunction
   function automatic logic [5:0] o_run(input logic [1:0] rc);
      return {4'b0010, rc};
   endfunction
   function automatic logic [5:0] o_fail(input logic [1:0] rc);
      return {4'b0101, rc};
   endfunction

   task automatic expect_at(input int c, input logic [5:0] e, input logic [7:0] l, input string nm);
      chk_t x;
      x.cyc      = c;
      x.exp      = e;
      x.exp_loss = l;
      x.name     = nm;
      sbq.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge rxclk_in);
   endtask

   always @(negedge rxclk_in) begin : monitor
      chk_t       e;
      logic [5:0] act;
      bit         ok;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         e   = sbq.pop_front();
         act = {dcm_rst, rx_reset, dcm_ready, lock_fail, retry_cnt};
         ok  = (e.cyc == cyc) && (act === e.exp);
`ifdef RX_DCM_LOSS_CNT_EN
         if (loss_cnt !== e.exp_loss) ok = 1'b0;
         if (!ok)
            $display("FAIL %s cyc=%0d due=%0d: got %b loss=%0d, want %b loss=%0d",
                     e.name, cyc, e.cyc, act, loss_cnt, e.exp, e.exp_loss);
`else
         if (!ok)
            $display("FAIL %s cyc=%0d due=%0d: got %b, want %b", e.name, cyc, e.cyc, act, e.exp);
`endif
         n_chk++;
         if (ok) n_pass++;
      end
   end

   initial begin
      int b;

      // Power-on reset held
      tick(2);
      b = cyc;
      expect_at(b + 1, o_rst(2'd0), 8'd0, "reset_values");
      tick(1);

      // 1: release reset, lock arrives 10 cycles later
      b = cyc;
      reset = 1'b0;
      expect_at(b + 1,  o_rst(2'd0),  8'd0, "s1_pulse_first");
      expect_at(b + 3,  o_rst(2'd0),  8'd0, "s1_pulse_last");
      expect_at(b + 4,  o_wait(2'd0), 8'd0, "s1_dcm_rst_fall");
      expect_at(b + 20, o_wait(2'd0), 8'd0, "s1_before_release");
      expect_at(b + 21, o_run(2'd0),  8'd0, "s1_release");
      tick(10);
      dcm_locked = 1'b1;
      tick(12);

      // 2: lock never arrives, retries then FAIL
      reset      = 1'b1;
      dcm_locked = 1'b0;
      tick(2);
      b = cyc;
      reset = 1'b0;
      expect_at(b + 35,  o_wait(2'd0), 8'd0, "s2_wait0_end");
      expect_at(b + 36,  o_rst(2'd1),  8'd0, "s2_retry1");
      expect_at(b + 39,  o_rst(2'd1),  8'd0, "s2_retry1_pulse_end");
      expect_at(b + 40,  o_wait(2'd1), 8'd0, "s2_wait1");
      expect_at(b + 71,  o_wait(2'd1), 8'd0, "s2_wait1_end");
      expect_at(b + 72,  o_rst(2'd2),  8'd0, "s2_retry2");
      expect_at(b + 75,  o_rst(2'd2),  8'd0, "s2_retry2_pulse_end");
      expect_at(b + 76,  o_wait(2'd2), 8'd0, "s2_wait2");
      expect_at(b + 107, o_wait(2'd2), 8'd0, "s2_wait2_end");
      expect_at(b + 108, o_fail(2'd2), 8'd0, "s2_fail");
      expect_at(b + 120, o_fail(2'd2), 8'd0, "s2_fail_held");
      tick(121);

      // 3: relock from FAIL, then lock
      b = cyc;
      relock_req = 1'b1;
      expect_at(b + 1,  o_rst(2'd0),  8'd0, "s3_relock_clear");
      expect_at(b + 4,  o_rst(2'd0),  8'd0, "s3_pulse_last");
      expect_at(b + 5,  o_wait(2'd0), 8'd0, "s3_wait");
      expect_at(b + 15, o_wait(2'd0), 8'd0, "s3_before_release");
      expect_at(b + 16, o_run(2'd0),  8'd0, "s3_release");
      tick(1);
      relock_req = 1'b0;
      tick(4);
      dcm_locked = 1'b1;
      tick(12);

      // 4: relock from RUN with lock held, one-cycle lock drop at stable count 5
      b = cyc;
      relock_req = 1'b1;
      expect_at(b + 1,  o_rst(2'd0),  8'd0, "s4_relock_run");
      expect_at(b + 5,  o_wait(2'd0), 8'd0, "s4_wait");
      expect_at(b + 14, o_wait(2'd0), 8'd0, "s4_glitch_holds_reset");
      expect_at(b + 22, o_wait(2'd0), 8'd0, "s4_before_release");
      expect_at(b + 23, o_run(2'd0),  8'd0, "s4_release");
      tick(1);
      relock_req = 1'b0;
      tick(10);
      dcm_locked = 1'b0;
      tick(1);
      dcm_locked = 1'b1;
      tick(12);

      // 5: lock loss in RUN
      b = cyc;
      dcm_locked = 1'b0;
      expect_at(b + 2,  o_run(2'd0),  8'd0, "s5_run_before_loss");
      expect_at(b + 3,  o_rst(2'd0),  8'd1, "s5_loss_reseq");
      expect_at(b + 7,  o_wait(2'd0), 8'd1, "s5_wait");
      expect_at(b + 50, o_wait(2'd1), 8'd1, "s6_wait_retry1");
      tick(50);

      // 6: asynchronous reset mid-WAIT_LOCK
      @(posedge rxclk_in);
      #1;
      reset = 1'b1;
      expect_at(cyc, o_rst(2'd0), 8'd0, "s6_async_reset");
      tick(2);
      b = cyc;
      reset = 1'b0;
      expect_at(b + 3, o_rst(2'd0),  8'd0, "s6_restart_pulse");
      expect_at(b + 4, o_wait(2'd0), 8'd0, "s6_restart_wait");
      tick(5);

      for (int i = 0; i < 20 && sbq.size() > 0; i++) tick(1);
      n_chk++;
      if (sbq.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
